// File: rtl/dbl_frame_buffer.sv
// dbl_frame_buffer: double-buffered frame store between a rasterizer and a display FIFO.
// The rasterizer writes addressed pixels into the back bank. A scanner streams the front
// bank in raster order into the display FIFO. The banks swap at a frame boundary, once the
// rasterizer is done and a swap has been requested. The new back bank can optionally be
// cleared after each swap.
// Ports:
//   clk, rst_n            single clock; synchronous active-low reset
//   next_frame_switch     swap request, latched until the swap happens
//   rast_pixel_rdy, rast_color_input, rast_x, rast_y    pixel write request
//   rast_done             rasterizer finished the current frame
//   read_rast_pixel_rdy   same-cycle acknowledge of a consumed pixel
//   dvi_fifo_full         display FIFO back-pressure
//   dvi_color_out, dvi_fifo_write_enable                 display push
//   front_sel             bank currently being displayed
//   swap_pending          request armed, waiting for the frame boundary
module dbl_frame_buffer #(
    parameter int unsigned        COLOR_W       = 3,
    parameter int unsigned        H_RES         = 640,
    parameter int unsigned        V_RES         = 480,
    parameter int unsigned        X_W           = 10,
    parameter int unsigned        Y_W           = 9,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR   = '0,
    parameter bit                 CLEAR_ON_SWAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               next_frame_switch,
    input  logic               rast_pixel_rdy,
    input  logic [COLOR_W-1:0] rast_color_input,
    input  logic [X_W-1:0]     rast_x,
    input  logic [Y_W-1:0]     rast_y,
    input  logic               rast_done,
    output logic               read_rast_pixel_rdy,
    input  logic               dvi_fifo_full,
    output logic [COLOR_W-1:0] dvi_color_out,
    output logic               dvi_fifo_write_enable,
    output logic               front_sel,
    output logic               swap_pending
);

    localparam int unsigned    PIX_N     = H_RES * V_RES;
    localparam int unsigned    A_W       = $clog2(PIX_N);
    // Full product width of y*H_RES + x for any input value.
    localparam int unsigned    P_W       = X_W + Y_W;
    localparam logic [A_W-1:0] LAST_ADDR = A_W'(PIX_N - 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_DRAW,
        ST_WAIT_SWAP
    } state_t;

    localparam state_t ST_AFTER_SWAP = CLEAR_ON_SWAP ? ST_CLEAR : ST_DRAW;

    state_t               state;
    state_t               state_nxt;
    logic [COLOR_W-1:0]   mem [2][PIX_N];
    logic [A_W-1:0]       clr_addr;
    logic [A_W-1:0]       scan_addr;
    logic                 hold_valid;
    logic                 swap_req;
    logic                 pix_in_range;
    logic                 wr_en;
    logic [A_W-1:0]       wr_addr;
    logic [COLOR_W-1:0]   wr_data;
    logic                 fetch;
    logic                 boundary;
    logic                 swap;

    assign pix_in_range = (32'(rast_x) < H_RES) && (32'(rast_y) < V_RES);

    // Scanner advances when the holding register is empty or is being pushed.
    assign fetch                 = ~hold_valid | ~dvi_fifo_full;
    assign boundary              = fetch & (scan_addr == LAST_ADDR);
    assign swap_pending          = swap_req & (state == ST_WAIT_SWAP);
    assign swap                  = boundary & swap_pending;
    assign dvi_fifo_write_enable = hold_valid & ~dvi_fifo_full;

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_AFTER_SWAP;
        end else begin
            state <= state_nxt;
        end
    end

    // Write FSM next state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_DRAW:      if (rast_done) state_nxt = ST_WAIT_SWAP;
            ST_WAIT_SWAP: if (swap) state_nxt = ST_AFTER_SWAP;
            ST_CLEAR:     if (clr_addr == LAST_ADDR) state_nxt = ST_DRAW;
            default:      state_nxt = ST_AFTER_SWAP;
        endcase
    end

    // Write FSM outputs: pixel ack and back-bank write port.
    always_comb begin
        read_rast_pixel_rdy = 1'b0;
        wr_en               = 1'b0;
        wr_addr             = '0;
        wr_data             = '0;
        case (state)
            ST_DRAW: begin
                read_rast_pixel_rdy = rast_pixel_rdy;
                wr_en               = rast_pixel_rdy & pix_in_range;
                // Only used when in range, where the value fits in A_W bits.
                wr_addr             = A_W'(P_W'(rast_y) * P_W'(H_RES) + P_W'(rast_x));
                wr_data             = rast_color_input;
            end
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_addr;
                wr_data = CLEAR_COLOR;
            end
            default: ;
        endcase
    end

    // Clear address; wraps to 0 on the last word so each clear starts at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + A_W'(1);
        end
    end

    // Back-bank write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[~front_sel][wr_addr] <= wr_data;
        end
    end

    // Scanner, holding register, swap request and bank select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_addr     <= '0;
            hold_valid    <= 1'b0;
            dvi_color_out <= '0;
            front_sel     <= 1'b0;
            swap_req      <= 1'b0;
        end else begin
            if (fetch) begin
                dvi_color_out <= mem[front_sel][scan_addr];
                hold_valid    <= 1'b1;
                scan_addr     <= (scan_addr == LAST_ADDR) ? '0 : scan_addr + A_W'(1);
            end
            // The last fetch of the frame still reads the old front bank.
            if (swap) begin
                front_sel <= ~front_sel;
            end
            swap_req <= (swap_req & ~swap) | next_frame_switch;
        end
    end

endmodule

// File: tb/tb_dbl_frame_buffer.sv
// Testbench for dbl_frame_buffer with an 8x4 frame and 3-bit colour.
module tb_dbl_frame_buffer;

    localparam int H       = 8;
    localparam int V       = 4;
    localparam int N       = H * V;
    localparam int CW      = 3;
    localparam int XW      = 4;
    localparam int YW      = 3;
    localparam int CLR_COL = 0;
    localparam int PH_CLR  = 0;
    localparam int PH_DRAW = 1;
    localparam int PH_WAIT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          nfs;
    logic          rdy;
    logic [CW-1:0] c;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          done;
    logic          ack;
    logic          full;
    logic [CW-1:0] color;
    logic          we;
    logic          front;
    logic          pend;

    dbl_frame_buffer #(
        .COLOR_W(CW), .H_RES(H), .V_RES(V), .X_W(XW), .Y_W(YW),
        .CLEAR_COLOR(3'(CLR_COL)), .CLEAR_ON_SWAP(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .next_frame_switch(nfs),
        .rast_pixel_rdy(rdy), .rast_color_input(c), .rast_x(x), .rast_y(y),
        .rast_done(done), .read_rast_pixel_rdy(ack), .dvi_fifo_full(full),
        .dvi_color_out(color), .dvi_fifo_write_enable(we),
        .front_sel(front), .swap_pending(pend)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int m_bank [2][N];
    bit m_known[2][N];
    bit m_valid = 1'b0;
    bit m_front, m_req, m_hv, m_hknown;
    int m_phase, m_clr, m_scan, m_hval;

    int push_cnt = 0;
    int cap[N];
    bit last_ack, last_we;

    typedef struct {
        bit rdy;
        int x;
        int y;
        int c;
        bit done;
        bit exp_ack;
        int exp_addr;
    } vec_t;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs applied this cycle.
    task automatic model_update();
        bit fetch, swp, back;
        if (!rst_n) begin
            m_valid = 1'b1; m_front = 1'b0; m_req = 1'b0; m_phase = PH_CLR;
            m_clr = 0; m_scan = 0; m_hv = 1'b0; m_hval = 0; m_hknown = 1'b1;
            push_cnt = 0;
            return;
        end
        if (!m_valid) return;
        fetch = !m_hv || !full;
        swp   = fetch && (m_scan == N - 1) && m_req && (m_phase == PH_WAIT);
        if (fetch) begin
            m_hval   = m_bank[m_front][m_scan];
            m_hknown = m_known[m_front][m_scan];
            m_hv     = 1'b1;
            m_scan   = (m_scan + 1) % N;
        end
        back = !m_front;
        case (m_phase)
            PH_DRAW: begin
                if (rdy && int'(x) < H && int'(y) < V) begin
                    m_bank[back][int'(y) * H + int'(x)]  = int'(c);
                    m_known[back][int'(y) * H + int'(x)] = 1'b1;
                end
                if (done) m_phase = PH_WAIT;
            end
            PH_WAIT: if (swp) m_phase = PH_CLR;
            default: begin
                m_bank[back][m_clr]  = CLR_COL;
                m_known[back][m_clr] = 1'b1;
                m_clr++;
                if (m_clr == N) begin
                    m_clr   = 0;
                    m_phase = PH_DRAW;
                end
            end
        endcase
        m_req = (m_req && !swp) || nfs;
        if (swp) m_front = !m_front;
    endtask

    // One clock: compare outputs against the model, record pushes, step the model.
    task automatic tick();
        #1;
        if (m_valid) begin
            chk("ack", ack, (m_phase == PH_DRAW) && rdy);
            chk("push", we, m_hv && !full);
            chk("swap_pending", pend, m_req && (m_phase == PH_WAIT));
            chk("front_sel", front, m_front);
            if (m_hknown) chk("color", color, m_hval);
        end
        last_ack = (ack === 1'b1);
        last_we  = (we === 1'b1);
        if (last_we) begin
            cap[push_cnt % N] = int'(color);
            push_cnt++;
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        vec_t vt[7];
        int   exp_img[N];
        int   n;
        int   start;

        vt[0] = '{1'b0, 1,  1, 7, 1'b0, 1'b0, -1};
        vt[1] = '{1'b1, 3,  2, 5, 1'b0, 1'b1, 19};
        vt[2] = '{1'b1, 8,  0, 6, 1'b0, 1'b1, -1};
        vt[3] = '{1'b1, 0,  4, 7, 1'b0, 1'b1, -1};
        vt[4] = '{1'b1, 15, 7, 3, 1'b0, 1'b1, -1};
        vt[5] = '{1'b1, 0,  0, 2, 1'b0, 1'b1, 0};
        vt[6] = '{1'b1, 7,  3, 6, 1'b1, 1'b1, 31};
        for (int i = 0; i < N; i++) exp_img[i] = CLR_COL;

        rst_n = 1'b0; nfs = 1'b0; rdy = 1'b0; c = '0; x = '0; y = '0;
        done = 1'b0; full = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state and first push latency.
        #1;
        chk("rst_front", front, 0);
        chk("rst_push", we, 0);
        chk("rst_color", color, 0);
        chk("rst_ack", ack, 0);
        chk("rst_pending", pend, 0);
        n = 0;
        do begin tick(); n++; end while (!last_we && n < 3);
        chk("first_push_within_3", last_we, 1);

        // Table-driven pixel writes, including out-of-range drops and done with a pixel.
        for (int i = 0; i < 7; i++) begin
            rdy  = vt[i].rdy;
            x    = XW'(vt[i].x);
            y    = YW'(vt[i].y);
            c    = CW'(vt[i].c);
            done = vt[i].done;
            n = 0;
            if (vt[i].rdy) begin
                do begin tick(); n++; end while (!last_ack && n < 100);
            end else begin
                tick();
            end
            chk($sformatf("vec%0d_ack", i), last_ack, vt[i].exp_ack);
            if (vt[i].exp_addr >= 0) exp_img[vt[i].exp_addr] = vt[i].c;
        end
        rdy = 1'b0; done = 1'b0;

        // Swap request after done; then capture one full frame of the new front bank.
        nfs = 1'b1; tick(); nfs = 1'b0;
        n = 0;
        while (front !== 1'b1 && n < 200) begin tick(); n++; end
        chk("swap1_front", front, 1);
        tick();
        n = 0;
        while ((push_cnt % N) != 0 && n < 100) begin tick(); n++; end
        start = push_cnt;
        n = 0;
        while (push_cnt < start + N && n < 200) begin tick(); n++; end
        chk("frame_len", push_cnt - start, N);
        for (int i = 0; i < N; i++) chk($sformatf("frame_w%0d", i), cap[i], exp_img[i]);

        // Request before done: not armed until done, then swap at the boundary.
        repeat (8) tick();
        nfs = 1'b1; tick(); nfs = 1'b0;
        repeat (5) tick();
        #1 chk("early_req_no_pending", pend, 0);
        done = 1'b1; tick(); done = 1'b0;
        #1 chk("early_req_pending", pend, 1);
        n = 0;
        while (front !== 1'b0 && n < 100) begin tick(); n++; end
        chk("swap2_front", front, 0);

        // Reset in the middle of a clear; the clear restarts from word 0.
        repeat (5) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        #1;
        chk("midclr_front", front, 0);
        chk("midclr_push", we, 0);
        chk("midclr_color", color, 0);
        chk("midclr_pending", pend, 0);
        rdy = 1'b1; x = 4'd1; y = 3'd1; c = 3'd3;
        n = 0;
        do begin tick(); n++; end while (!last_ack && n < 100);
        chk("clear_len", n - 1, N);
        rdy = 1'b0;

        // Reset while a swap is pending with bank 1 in front.
        done = 1'b1; nfs = 1'b1; tick(); done = 1'b0; nfs = 1'b0;
        #1 chk("both_same_cycle_pending", pend, 1);
        n = 0;
        while (front !== 1'b1 && n < 100) begin tick(); n++; end
        chk("swap3_front", front, 1);
        repeat (40) tick();
        done = 1'b1; nfs = 1'b1; tick(); done = 1'b0; nfs = 1'b0;
        #1 chk("pend_before_rst", pend, 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        #1;
        chk("pendrst_front", front, 0);
        chk("pendrst_pending", pend, 0);
        chk("pendrst_push", we, 0);

        // Random back-pressure and rasterizer traffic against the model.
        for (int i = 0; i < 500; i++) begin
            full = 1'($urandom_range(0, 1));
            rdy  = 1'($urandom_range(0, 1));
            x    = XW'($urandom_range(0, 9));
            y    = YW'($urandom_range(0, 5));
            c    = CW'($urandom);
            done = ($urandom_range(0, 15) == 0);
            nfs  = ($urandom_range(0, 15) == 0);
            tick();
        end
        full = 1'b0; rdy = 1'b0; done = 1'b0; nfs = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
